// File: rtl/multiport_mem_controller.sv
// multiport_mem_controller: banked BRAM front end for NUM_PORTS requesters.
// Each bank has a round-robin arbiter. Every accepted request (read, write
// ack, or error) gets exactly one response two cycles after acceptance.
// Banks can be power-gated; a bank stalls for WAKE_CYCLES after it re-powers.
//
// Handshake: a port raises req_valid and holds its request stable until it
// sees req_ready high in the same cycle; that cycle is the accept cycle T.
// The response for that request is a one-cycle resp_valid pulse in cycle T+2.
module multiport_mem_controller #(
  parameter int NUM_PORTS       = 2,
  parameter int BANKS           = 20,
  parameter int BANK_SEL_WIDTH  = 5,
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 16,
  parameter int BRAM_ADDR_WIDTH = 12,
  parameter int WAKE_CYCLES     = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_PORTS-1:0]                req_valid,
  output logic [NUM_PORTS-1:0]                req_ready,
  input  logic [NUM_PORTS-1:0]                req_we,
  input  logic [NUM_PORTS*BANK_SEL_WIDTH-1:0] req_bank,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     req_wdata,
  output logic [NUM_PORTS-1:0]                resp_valid,
  output logic [NUM_PORTS-1:0]                resp_err,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]     resp_data,
  input  logic [BANKS-1:0]                    bank_power_en,
  output logic [BANKS-1:0]                    bram_en,
  output logic [BANKS-1:0]                    bram_we,
  output logic [BANKS*BRAM_ADDR_WIDTH-1:0]    bram_addr,
  output logic [BANKS*DATA_WIDTH-1:0]         bram_din,
  input  logic [BANKS*DATA_WIDTH-1:0]         bram_dout
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int WW = (WAKE_CYCLES > 0) ? $clog2(WAKE_CYCLES + 1) : 1;

  // Per-port decode
  logic [BANK_SEL_WIDTH-1:0]  p_bank [NUM_PORTS];
  logic [NUM_PORTS-1:0]       p_err;

  // Per-bank state
  logic [BANKS-1:0]           pwr_q;
  logic [WW-1:0]              wake_q [BANKS];
  logic [WW-1:0]              wake_d [BANKS];
  logic [PW-1:0]              ptr_q  [BANKS];
  logic [PW-1:0]              ptr_d  [BANKS];
  logic [BRAM_ADDR_WIDTH-1:0] addr_q [BANKS];
  logic [DATA_WIDTH-1:0]      din_q  [BANKS];

  // Arbitration results
  logic [BANKS-1:0]           gnt_any;
  logic [PW-1:0]              win [BANKS];
  logic [NUM_PORTS-1:0]       port_gnt;
  logic [NUM_PORTS-1:0]       acc;

  // Response pipeline: stage 1 holds the tag while the BRAM read completes
  logic [NUM_PORTS-1:0]       s1_valid_q;
  logic [NUM_PORTS-1:0]       s1_err_q;
  logic [NUM_PORTS-1:0]       s1_read_q;
  logic [BANK_SEL_WIDTH-1:0]  s1_bank_q [NUM_PORTS];
  logic [DATA_WIDTH-1:0]      s1_dout   [NUM_PORTS];
  logic [NUM_PORTS-1:0]       resp_valid_q;
  logic [NUM_PORTS-1:0]       resp_err_q;
  logic [DATA_WIDTH-1:0]      resp_data_q [NUM_PORTS];

  // Error class: bad bank, address beyond bank depth, or unpowered bank
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      p_bank[p] = req_bank[p*BANK_SEL_WIDTH +: BANK_SEL_WIDTH];
      p_err[p]  = 1'b0;
      if (int'(p_bank[p]) >= BANKS) p_err[p] = 1'b1;
      else if (!bank_power_en[p_bank[p]]) p_err[p] = 1'b1;
      if (req_addr[p*ADDR_WIDTH+BRAM_ADDR_WIDTH +: ADDR_WIDTH-BRAM_ADDR_WIDTH] != '0)
        p_err[p] = 1'b1;
    end
  end

  // Wake counters: load on power rise, clear on power fall, count down otherwise
  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      wake_d[b] = wake_q[b];
      if (!bank_power_en[b] && pwr_q[b])      wake_d[b] = '0;
      else if (bank_power_en[b] && !pwr_q[b]) wake_d[b] = WW'(WAKE_CYCLES);
      else if (wake_q[b] != '0)               wake_d[b] = wake_q[b] - 1'b1;
    end
  end

  // Per-bank round-robin: first valid non-error requester at or after the pointer
  always_comb begin
    int idx;
    idx      = 0;
    port_gnt = '0;
    for (int b = 0; b < BANKS; b++) begin
      gnt_any[b] = 1'b0;
      win[b]     = '0;
      ptr_d[b]   = ptr_q[b];
      if (rst_n && wake_q[b] == '0) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          idx = (int'(ptr_q[b]) + i) % NUM_PORTS;
          if (!gnt_any[b] && req_valid[idx] && !p_err[idx] && int'(p_bank[idx]) == b) begin
            gnt_any[b]    = 1'b1;
            win[b]        = PW'(idx);
            port_gnt[idx] = 1'b1;
            ptr_d[b]      = PW'((idx + 1) % NUM_PORTS);
          end
        end
      end
    end
  end

  // Errors are accepted at once; good requests only when their bank grants them
  assign req_ready = {NUM_PORTS{rst_n}} & req_valid & (p_err | port_gnt);
  assign acc       = req_valid & req_ready;

  // BRAM drive in the accept cycle; idle banks keep their last addr/din
  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      bram_en[b]                                     = gnt_any[b];
      bram_we[b]                                     = 1'b0;
      bram_addr[b*BRAM_ADDR_WIDTH +: BRAM_ADDR_WIDTH] = addr_q[b];
      bram_din[b*DATA_WIDTH +: DATA_WIDTH]           = din_q[b];
      if (gnt_any[b]) begin
        bram_we[b] = req_we[win[b]];
        bram_addr[b*BRAM_ADDR_WIDTH +: BRAM_ADDR_WIDTH] =
          req_addr[int'(win[b])*ADDR_WIDTH +: BRAM_ADDR_WIDTH];
        bram_din[b*DATA_WIDTH +: DATA_WIDTH] =
          req_wdata[int'(win[b])*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Pick the read data of the bank each in-flight request is tagged with
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      s1_dout[p] = '0;
      for (int b = 0; b < BANKS; b++)
        if (int'(s1_bank_q[p]) == b) s1_dout[p] = bram_dout[b*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Outputs of the response pipeline
  always_comb begin
    resp_valid = resp_valid_q;
    resp_err   = resp_err_q;
    for (int p = 0; p < NUM_PORTS; p++) resp_data[p*DATA_WIDTH +: DATA_WIDTH] = resp_data_q[p];
  end

  // All sequential state: bank status, RR pointers, held BRAM drive, response pipe.
  // pwr_q follows the power inputs during reset so powered banks do not stall after it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwr_q        <= bank_power_en;
      s1_valid_q   <= '0;
      s1_err_q     <= '0;
      s1_read_q    <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= '0;
      for (int b = 0; b < BANKS; b++) begin
        wake_q[b] <= '0;
        ptr_q[b]  <= '0;
        addr_q[b] <= '0;
        din_q[b]  <= '0;
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        s1_bank_q[p]   <= '0;
        resp_data_q[p] <= '0;
      end
    end else begin
      pwr_q <= bank_power_en;
      for (int b = 0; b < BANKS; b++) begin
        wake_q[b] <= wake_d[b];
        ptr_q[b]  <= ptr_d[b];
        if (gnt_any[b]) begin
          addr_q[b] <= bram_addr[b*BRAM_ADDR_WIDTH +: BRAM_ADDR_WIDTH];
          din_q[b]  <= bram_din[b*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      s1_valid_q   <= acc;
      s1_err_q     <= p_err;
      s1_read_q    <= ~req_we;
      resp_valid_q <= s1_valid_q;
      resp_err_q   <= s1_valid_q & s1_err_q;
      for (int p = 0; p < NUM_PORTS; p++) begin
        s1_bank_q[p]   <= p_bank[p];
        resp_data_q[p] <= (s1_valid_q[p] && s1_read_q[p] && !s1_err_q[p]) ? s1_dout[p] : '0;
      end
    end
  end

endmodule

// File: doc/multiport_mem_controller.md
Name: multiport_mem_controller

Overview:
Parametrised banked BRAM controller that serves NUM_PORTS independent requesters (e.g. DMA, compute core, host) over BANKS single-port BRAM banks. Each bank has its own round-robin arbiter. Every accepted request gets a fixed-latency response, with an error flag. Banks are power-gated by bank_power_en, with a wake-up stall after re-enable. It replaces the single-requester controller between the accelerator datapath and the bram_bank instances.

Parameters:
NUM_PORTS, 2, number of requester ports (1..8)
BANKS, 20, number of BRAM banks
BANK_SEL_WIDTH, 5, bank select width; must satisfy 2^BANK_SEL_WIDTH >= BANKS
DATA_WIDTH, 8, data word width
ADDR_WIDTH, 16, request address width
BRAM_ADDR_WIDTH, 12, bank address width (depth 2^BRAM_ADDR_WIDTH)
WAKE_CYCLES, 4, stall cycles after a bank's power enable rises (0 = no stall)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_PORTS  per-port request valid
req_ready  out  NUM_PORTS  per-port request accepted this cycle (combinational)
req_we  in  NUM_PORTS  1 = write, 0 = read
req_bank  in  NUM_PORTS*BANK_SEL_WIDTH  bank select, port p at slice p
req_addr  in  NUM_PORTS*ADDR_WIDTH  word address
req_wdata  in  NUM_PORTS*DATA_WIDTH  write data
resp_valid  out  NUM_PORTS  one-cycle response pulse
resp_err  out  NUM_PORTS  response carries error (valid with resp_valid)
resp_data  out  NUM_PORTS*DATA_WIDTH  read data (0 for writes and errors)
bank_power_en  in  BANKS  1 = bank powered
bram_en  out  BANKS  bank enable
bram_we  out  BANKS  bank write enable
bram_addr  out  BANKS*BRAM_ADDR_WIDTH  bank address
bram_din  out  BANKS*DATA_WIDTH  bank write data
bram_dout  in  BANKS*DATA_WIDTH  bank read data, valid one cycle after bram_en

Behaviour:
- Handshake: a request is accepted in a cycle where req_valid & req_ready are both high. The port must hold its request stable until accepted.
- Error class, decoded combinationally: any of req_bank >= BANKS, req_addr[ADDR_WIDTH-1:BRAM_ADDR_WIDTH] != 0, or bank_power_en of the target bank low.
  - Error requests are always ready immediately and never touch any BRAM.
  - A write to an unpowered bank is dropped.
- Wake stall:
  - A per-bank counter loads WAKE_CYCLES on a 0->1 edge of bank_power_en and decrements to 0.
  - While the counter is nonzero, non-error requests to that bank get ready = 0.
  - A 1->0 edge clears the counter.
- Arbitration, per bank, among ports with valid non-error requests to that bank:
  - Round-robin; a per-bank pointer starts at port 0.
  - Winner = first requesting port at or after the pointer, wrapping.
  - On grant, the pointer becomes winner+1 mod NUM_PORTS.
  - Losers see ready = 0.
  - Different banks grant in parallel; each port gets at most one grant per cycle.
- BRAM drive is combinational in the accept cycle T:
  - bram_en = 1 and bram_we = req_we for the granted bank.
  - bram_addr = req_addr[BRAM_ADDR_WIDTH-1:0] and bram_din = wdata of the granted port.
  - Ungranted banks get en = we = 0; addr and din hold their last value.
- Response: exactly one per accepted request, resp_valid high in cycle T+2 for every type (read, write ack, error).
  - A 2-stage per-port pipeline carries {valid, err, is_read, bank}.
  - Stage 1 captures bram_dout of the tagged bank in cycle T+1.
  - Responses per port are in order.
  - Back-to-back accepts give back-to-back responses, throughput 1 per port per cycle.
- Read-after-write to the same address in consecutive cycles returns the new data.
- Reset, synchronous, while rst_n = 0:
  - Outputs: resp_valid = 0, resp_err = 0, resp_data = 0, bram_en = 0, bram_we = 0, req_ready = 0.
  - State: in-flight responses discarded, RR pointers = 0, wake counters = 0.
- After reset, powered banks are immediately available with no wake stall.

Test Plan:
1. Single port: write bank 0 addr 0x0010 = 0xAA, then read it -> resp_valid at accept+2, resp_data = 0xAA, resp_err = 0. The write ack also pulses at accept+2 with data 0.
2. Ports 0 and 1 both read bank 4 continuously for 4 cycles -> grants alternate 0,1,0,1 with ready mutually exclusive. Ports 0 and 1 hitting banks 4 and 5 are both granted every cycle.
3. Power gating:
   - Drop bank_power_en[4] and write 0xDD to bank 4 addr 0x20 -> ready immediately, resp_err = 1, bram_en[4] never asserted.
   - Re-enable -> ready low for exactly 4 cycles; then read addr 0x20 returns the old 0xBB.
4. Bank 25 or addr 0x1000 (bit 12 set) -> ready immediately, resp_err = 1, resp_data = 0, no bram_en.
5. Burst: port 0 writes addrs 0..15 = index back-to-back, then reads 0..15 back-to-back -> 16 consecutive resp_valid pulses with data 0..15 in order.
6. Assert rst_n = 0 for one cycle between the accept and the response -> no resp_valid afterwards, and RR restarts at port 0.
